// File: rtl/conv_frame_sequencer.sv
// Frame controller for the conv engine: 3x3 zero-padded conv pass into L0_MEM0, then a
// 2x2/stride-2 max-pool pass from L0_MEM0 into L1_MEM0. Every output is registered.
module conv_frame_sequencer #(
  parameter int IMG_W  = 64,
  parameter int LOG_W  = 6,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              pad_zero,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [3:0]        tap_idx,
  output logic              conv_done,
  output logic              pool_clr,
  output logic              pool_en,
  output logic              wsel_pool,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel
);

  typedef enum logic [2:0] {IDLE, C_RD, C_DONE, C_WR, P_RD, P_WR, DONE} state_t;

  state_t             state, nstate;
  logic [3:0]         t, nt;
  logic [LOG_W-1:0]   x, y, nx, ny;
  logic [LOG_W-2:0]   px, py, npx, npy;
  logic [ADDR_W:0]    rd_tap;
  logic               iaddr_pad;

  // Row/col are (LOG_W+1)-bit two's complement; both -1 and IMG_W set the MSB, which is the pad flag.
  function automatic logic [ADDR_W:0] tap_addr(input logic [LOG_W-1:0] ty, tx, input logic [3:0] k);
    logic [1:0]     kr, kc;
    logic [LOG_W:0] r, c;
    logic           pad;
    kr  = (k < 4'd3) ? 2'd0 : (k < 4'd6) ? 2'd1 : 2'd2;
    kc  = 2'(k - 4'(kr) * 4'd3);
    r   = {1'b0, ty} + (LOG_W+1)'(kr) - (LOG_W+1)'(1);
    c   = {1'b0, tx} + (LOG_W+1)'(kc) - (LOG_W+1)'(1);
    pad = r[LOG_W] | c[LOG_W];
    return {pad, pad ? {ADDR_W{1'b0}} : {r[LOG_W-1:0], c[LOG_W-1:0]}};
  endfunction

  always_comb begin
    nstate = state;
    nt     = t;
    nx     = x;
    ny     = y;
    npx    = px;
    npy    = py;
    case (state)
      IDLE: if (ready) begin
        nstate = C_RD; nt = 4'd0; nx = '0; ny = '0;
      end
      C_RD: if (t == 4'd9) begin nstate = C_DONE; nt = 4'd10; end
            else nt = 4'(t + 4'd1);
      C_DONE: begin nstate = C_WR; nt = 4'd11; end
      C_WR: begin
        nt = 4'd0;
        nx = x + LOG_W'(1);
        if (&x) ny = y + LOG_W'(1);
        if (&x && &y) begin nstate = P_RD; npx = '0; npy = '0; end
        else nstate = C_RD;
      end
      P_RD: if (t == 4'd4) begin nstate = P_WR; nt = 4'd5; end
            else nt = 4'(t + 4'd1);
      P_WR: begin
        nt  = 4'd0;
        npx = px + (LOG_W-1)'(1);
        if (&px) npy = py + (LOG_W-1)'(1);
        nstate = (&px && &py) ? DONE : P_RD;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign rd_tap = tap_addr(ny, nx, nt);

  // Outputs are decoded from the next state so they line up with the cycle they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE; t <= '0; x <= '0; y <= '0; px <= '0; py <= '0;
      busy <= 1'b0; iaddr <= '0; iaddr_pad <= 1'b0; pad_zero <= 1'b0;
      mac_clr <= 1'b0; mac_en <= 1'b0; tap_idx <= '0; conv_done <= 1'b0;
      pool_clr <= 1'b0; pool_en <= 1'b0; wsel_pool <= 1'b0; cwr <= 1'b0;
      caddr_wr <= '0; crd <= 1'b0; caddr_rd <= '0; csel <= 3'b000;
    end else begin
      state <= nstate; t <= nt; x <= nx; y <= ny; px <= npx; py <= npy;
      busy      <= (nstate != IDLE);
      iaddr     <= (nstate == C_RD && nt <= 4'd8) ? rd_tap[ADDR_W-1:0] : '0;
      iaddr_pad <= (nstate == C_RD && nt <= 4'd8) & rd_tap[ADDR_W];
      // Tap data lands one cycle after its address, so the mac stage trails the reads by one.
      mac_en    <= (nstate == C_RD && nt >= 4'd1);
      mac_clr   <= (nstate == C_RD && nt == 4'd1);
      tap_idx   <= (nstate == C_RD && nt >= 4'd1) ? 4'(nt - 4'd1) : 4'd0;
      pad_zero  <= (nstate == C_RD && nt >= 4'd1) & iaddr_pad;
      conv_done <= (nstate == C_DONE);
      crd       <= (nstate == P_RD && nt <= 4'd3);
      caddr_rd  <= (nstate == P_RD && nt <= 4'd3) ? {npy, nt[1], npx, nt[0]} : '0;
      pool_en   <= (nstate == P_RD && nt >= 4'd1);
      pool_clr  <= (nstate == P_RD && nt == 4'd1);
      cwr       <= (nstate == C_WR) || (nstate == P_WR);
      wsel_pool <= (nstate == P_WR);
      caddr_wr  <= (nstate == C_WR) ? {ny, nx} :
                   (nstate == P_WR) ? ADDR_W'({npy, npx}) : '0;
      // L0 stays selected through the last pool drain cycle so the switch to L1 has no gap.
      csel      <= (nstate == C_WR || nstate == P_RD) ? 3'b001 :
                   (nstate == P_WR) ? 3'b011 : 3'b000;
    end
  end

endmodule
